// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver.
// The serial line is synchronized into rx_s and then framed by a
// five-state FSM. Each clean frame produces a single one-cycle write
// strobe to the RX FIFO. A bad stop bit or a full FIFO instead sets a
// sticky error flag.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_en,
  input  logic [15:0]          baud_div,
  input  logic                 rx_in,
  input  logic                 rx_fifo_full,
  input  logic                 err_clear,
  output logic [DATA_BITS-1:0] rx_fifo_data_in,
  output logic                 rx_fifo_write,
  output logic                 rx_frame_error,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int BCW = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [15:0]          baud_cnt;
  logic [15:0]          div_eff;
  logic                 tick;
  logic [3:0]           tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS:0]   shift_ext;

  // Two-flop synchronizer; both flops reset to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // A divisor of zero behaves as a divisor of one
  assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;

  // The >= comparison lets a divisor lowered mid-count still reload instead of wrapping
  assign tick = uart_en && (state != IDLE) && (baud_cnt >= (div_eff - 16'd1));

  // Oversample prescaler: parked at 0 when disabled or idle, reloads on every tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= 16'd0;
    end else if (!uart_en || (state == IDLE) || tick) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // The next sample enters at the MSB, so after DATA_BITS shifts the first bit sits at the LSB
  assign shift_ext = {rx_s, shift_reg};

  // Receive FSM with registered write strobe, output byte and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      tick_cnt        <= 4'd0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      rx_fifo_data_in <= '0;
      rx_fifo_write   <= 1'b0;
      rx_frame_error  <= 1'b0;
      rx_overrun      <= 1'b0;
    end else begin
      rx_fifo_write <= 1'b0;
      // Clear comes first so that a set later in this block takes priority
      if (err_clear) begin
        rx_frame_error <= 1'b0;
        rx_overrun     <= 1'b0;
      end
      if (!uart_en) begin
        state    <= IDLE;
        tick_cnt <= 4'd0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= 4'd0;
              bit_cnt  <= '0;
            end
          end
          START: begin
            if (tick) begin
              if (tick_cnt == 4'd7) begin
                tick_cnt <= 4'd0;
                if (rx_s) begin
                  state <= IDLE;
                end else begin
                  state   <= DATA;
                  bit_cnt <= '0;
                end
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) begin
                shift_reg <= shift_ext[DATA_BITS:1];
                if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                  state   <= STOP;
                  bit_cnt <= '0;
                end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
                end
              end
            end
          end
          STOP: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) begin
                if (rx_s) begin
                  if (!rx_fifo_full) begin
                    rx_fifo_data_in <= shift_reg;
                    rx_fifo_write   <= 1'b1;
                  end else begin
                    rx_overrun <= 1'b1;
                  end
                  state <= IDLE;
                end else begin
                  rx_frame_error <= 1'b1;
                  state          <= BREAK;
                end
              end
            end
          end
          BREAK: begin
            tick_cnt <= 4'd0;
            if (rx_s) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx at 8 data bits.
module tb_uart_rx;

  localparam int BITP = 64;

  logic       clk;
  logic       rst_n;
  logic       uart_en;
  logic [15:0] baud_div;
  logic       rx_in;
  logic       rx_fifo_full;
  logic       err_clear;
  logic [7:0] rx_fifo_data_in;
  logic       rx_fifo_write;
  logic       rx_frame_error;
  logic       rx_overrun;
  logic       rx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  logic [7:0] wr_q[$];

  uart_rx #(.DATA_BITS(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .uart_en         (uart_en),
    .baud_div        (baud_div),
    .rx_in           (rx_in),
    .rx_fifo_full    (rx_fifo_full),
    .err_clear       (err_clear),
    .rx_fifo_data_in (rx_fifo_data_in),
    .rx_fifo_write   (rx_fifo_write),
    .rx_frame_error  (rx_frame_error),
    .rx_overrun      (rx_overrun),
    .rx_busy         (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe together with its byte
  always @(negedge clk) begin
    if (rx_fifo_write === 1'b1) begin
      wr_count = wr_count + 1;
      wr_q.push_back(rx_fifo_data_in);
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; leaves rx_in at the stop-bit level
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bitp);
    rx_in = 1'b0;
    repeat (bitp) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (bitp) @(posedge clk);
      #1;
    end
    rx_in = stop_bit;
    repeat (bitp) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_en = 1'b1;
    baud_div = 16'd4;
    rx_in = 1'b1;
    rx_fifo_full = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (rx_fifo_data_in !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_fifo_data_in); end
    n_tests++; if (rx_fifo_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", rx_fifo_write); end
    n_tests++; if (rx_frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_error); end
    n_tests++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", rx_overrun); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    align();
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_single_a5();
    int base;
    int lat;
    base = wr_count;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, BITP);
      begin
        for (int i = 1; i <= 1000; i++) begin
          @(posedge clk);
          #1;
          if (rx_fifo_write === 1'b1) begin
            lat = i;
            break;
          end
        end
      end
    join
    idle(100);
    n_tests++; if (lat < 610 || lat > 612) begin n_fail++; $display("FAIL a5_latency: got %0d expected 611", lat); end
    n_tests++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL a5_count: got %0d expected 1", wr_count - base); end
    n_tests++; if (wr_q[base] !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h expected a5", wr_q[base]); end
    n_tests++; if (rx_frame_error !== 1'b0 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL a5_flags: got %b%b expected 00", rx_frame_error, rx_overrun); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = wr_count;
    send_frame(8'h00, 1'b1, BITP);
    send_frame(8'hFF, 1'b1, BITP);
    send_frame(8'h3C, 1'b1, BITP);
    idle(100);
    n_tests++; if (wr_count - base !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", wr_count - base); end
    n_tests++; if (wr_q[base] !== 8'h00) begin n_fail++; $display("FAIL b2b_data0: got %h expected 00", wr_q[base]); end
    n_tests++; if (wr_q[base+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_data1: got %h expected ff", wr_q[base+1]); end
    n_tests++; if (wr_q[base+2] !== 8'h3C) begin n_fail++; $display("FAIL b2b_data2: got %h expected 3c", wr_q[base+2]); end
  endtask

  task automatic test_glitch();
    int base;
    base = wr_count;
    rx_in = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: got %b expected 1", rx_busy); end
    align();
    idle(5);
    rx_in = 1'b1;
    idle(100);
    @(negedge clk);
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: got %b expected 0", rx_busy); end
    n_tests++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL glitch_write: got %0d expected 0", wr_count - base); end
    n_tests++; if (rx_frame_error !== 1'b0 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL glitch_flags: got %b%b expected 00", rx_frame_error, rx_overrun); end
    align();
  endtask

  task automatic test_break();
    int base;
    int idle_cycles;
    base = wr_count;
    idle_cycles = 0;
    send_frame(8'h55, 1'b0, BITP);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_busy !== 1'b1) idle_cycles++;
    end
    align();
    n_tests++; if (idle_cycles !== 0) begin n_fail++; $display("FAIL break_held: got %0d idle cycles expected 0", idle_cycles); end
    n_tests++; if (rx_frame_error !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b expected 1", rx_frame_error); end
    n_tests++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL break_write: got %0d expected 0", wr_count - base); end
    n_tests++; if (rx_fifo_data_in !== 8'h3C) begin n_fail++; $display("FAIL break_hold_data: got %h expected 3c", rx_fifo_data_in); end
    rx_in = 1'b1;
    idle(20);
    @(negedge clk);
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_exit: got %b expected 0", rx_busy); end
    n_tests++; if (rx_frame_error !== 1'b1) begin n_fail++; $display("FAIL break_sticky: got %b expected 1", rx_frame_error); end
    align();
    err_clear = 1'b1;
    align();
    err_clear = 1'b0;
    @(negedge clk);
    n_tests++; if (rx_frame_error !== 1'b0) begin n_fail++; $display("FAIL break_clear: got %b expected 0", rx_frame_error); end
    align();
  endtask

  task automatic test_overrun();
    int base;
    base = wr_count;
    rx_fifo_full = 1'b1;
    fork
      send_frame(8'h81, 1'b1, BITP);
      begin
        repeat (610) @(posedge clk);
        #1;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
      end
    join
    idle(50);
    rx_fifo_full = 1'b0;
    idle(10);
    n_tests++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL ovr_write: got %0d expected 0", wr_count - base); end
    n_tests++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b expected 1", rx_overrun); end
    n_tests++; if (rx_frame_error !== 1'b0) begin n_fail++; $display("FAIL ovr_ferr: got %b expected 0", rx_frame_error); end
  endtask

  task automatic test_enable_drop();
    int base;
    logic busy_after;
    base = wr_count;
    busy_after = 1'b1;
    fork
      send_frame(8'hF0, 1'b1, BITP);
      begin
        repeat (BITP * 5 + 32) @(posedge clk);
        #1;
        uart_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        busy_after = rx_busy;
      end
    join
    idle(50);
    n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL en_drop_idle: got %b expected 0", busy_after); end
    n_tests++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL en_drop_sticky: got %b expected 1", rx_overrun); end
    uart_en = 1'b1;
    idle(20);
    send_frame(8'h12, 1'b1, BITP);
    idle(100);
    n_tests++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL en_count: got %0d expected 1", wr_count - base); end
    n_tests++; if (wr_q[base] !== 8'h12) begin n_fail++; $display("FAIL en_data: got %h expected 12", wr_q[base]); end
    err_clear = 1'b1;
    align();
    err_clear = 1'b0;
    @(negedge clk);
    n_tests++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", rx_overrun); end
    align();
  endtask

  task automatic test_div_zero();
    int base;
    base = wr_count;
    baud_div = 16'd0;
    idle(5);
    send_frame(8'h5A, 1'b1, 16);
    idle(50);
    n_tests++; if (wr_count - base !== 1) begin n_fail++; $display("FAIL div0_count: got %0d expected 1", wr_count - base); end
    n_tests++; if (wr_q[base] !== 8'h5A) begin n_fail++; $display("FAIL div0_data: got %h expected 5a", wr_q[base]); end
    baud_div = 16'd4;
    idle(5);
  endtask

  task automatic test_reset_midframe();
    int base;
    base = wr_count;
    fork
      send_frame(8'hF8, 1'b1, BITP);
      begin
        repeat (74) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    idle(200);
    @(negedge clk);
    n_tests++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL rstmid_write: got %0d expected 0", wr_count - base); end
    n_tests++; if (rx_fifo_data_in !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", rx_fifo_data_in); end
    n_tests++; if (rx_busy !== 1'b0 || rx_frame_error !== 1'b0 || rx_overrun !== 1'b0 || rx_fifo_write !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b ferr=%b ovr=%b wr=%b expected all 0", rx_busy, rx_frame_error, rx_overrun, rx_fifo_write);
    end
    align();
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_enable_drop();
    test_div_zero();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: uart_en  input  1  receiver enable.
REQ-005 SHALL have port: baud_div  input  16  clk cycles per 16x oversample tick.
REQ-006 SHALL have port: rx_in  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port: rx_fifo_full  input  1  downstream RX FIFO full.
REQ-008 SHALL have port: err_clear  input  1  one-cycle pulse; clears sticky error flags.
REQ-009 SHALL have port: rx_fifo_data_in  output  DATA_BITS  received byte to RX FIFO.
REQ-010 SHALL have port: rx_fifo_write  output  1  one-cycle RX FIFO write strobe.
REQ-011 SHALL have port: rx_frame_error  output  1  sticky framing-error flag.
REQ-012 SHALL have port: rx_overrun  output  1  sticky overrun flag.
REQ-013 SHALL have port: rx_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL pass rx_in through a 2-flop synchronizer; the synchronized value (rx_s) is the only value the receiver uses.
REQ-015 SHALL generate a one-cycle oversample tick every baud_div clk cycles.
- baud_div = 0 is treated as 1.
- The tick counter is held at 0 while uart_en = 0, or while in IDLE.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, BREAK, with a 4-bit tick counter and a bit counter of width clog2(DATA_BITS)+1.
REQ-017 IDLE: rx_s = 0 SHALL transition to START, clearing the tick counter and the oversample count.
REQ-018 START: on the 8th tick (mid start bit), sample rx_s.
- rx_s = 1: return to IDLE (glitch rejection); no flag is set.
- rx_s = 0: go to DATA with bit count 0.
REQ-019 DATA: every 16th tick, sample rx_s into the shift register LSB-first.
- After DATA_BITS samples, go to STOP.
REQ-020 STOP: on the 16th tick, sample rx_s.
- rx_s = 1 and rx_fifo_full = 0: on the next clk, rx_fifo_write = 1 for exactly one cycle, rx_fifo_data_in = shifted byte; go to IDLE.
- rx_s = 1 and rx_fifo_full = 1: byte dropped, rx_overrun set, no write; go to IDLE.
- rx_s = 0: byte dropped, rx_frame_error set, no write; go to BREAK.
REQ-021 BREAK: remain until rx_s = 1, then go to IDLE; a held-low line SHALL NOT produce repeated frames.
REQ-022 rx_fifo_data_in SHALL hold its last written value until the next successful frame.
REQ-023 Sticky flags are cleared only by err_clear or reset. When a set event and err_clear occur in the same cycle, set SHALL win.
REQ-024 uart_en deasserted mid-frame SHALL force IDLE on the next clk with no write and no flag change; the sticky flags SHALL be retained.
REQ-025 baud_div changes SHALL take effect at the next tick-counter reload; behaviour within the in-flight frame is undefined.
REQ-026 Latency from the rx_in start falling edge to rx_fifo_write SHALL be 2 synchronizer cycles + (8+16*(DATA_BITS+1))*baud_div + 1 clk.

Reset
REQ-027 On rst_n low, the block SHALL enter the following values:
- state = IDLE; counters = 0; synchronizer flops = 1.
- rx_fifo_data_in = 0; rx_fifo_write = 0; rx_frame_error = 0; rx_overrun = 0; rx_busy = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no write strobe after release.

Verification
REQ-029 baud_div=4, uart_en=1, serial 0xA5 (8N1, 64 clk/bit) -> single rx_fifo_write with data 0xA5, 611 clk after start edge (±1); flags stay 0.
REQ-030 Back-to-back 0x00, 0xFF, 0x3C at baud_div=4 -> three write strobes with data 0x00, 0xFF, 0x3C in order, no extra strobes.
REQ-031 Line low for 16 clk (< 8 ticks at baud_div=4) then high -> no write, rx_busy returns to 0, no flags.
REQ-032 Frame 0x55 with stop bit driven 0, then line held low for 2000 clk -> rx_frame_error=1, no write, single BREAK entry; err_clear pulse -> flag 0.
REQ-033 rx_fifo_full=1 during frame 0x81 -> no write, rx_overrun=1; err_clear asserted in the same cycle as the overrun event -> rx_overrun remains 1.
REQ-034 uart_en dropped at bit 4 of 0xF0, re-enabled, then 0x12 sent -> only one write, data 0x12; rst_n pulse mid-frame -> no write, all outputs 0.
